bp_fe_parcel_realigner: RTL and testbench

Parametrised fetch realigner that accepts I$ fetch blocks of `fetch_parcels_p` 16-bit parcels, buffers them in a circular parcel queue, and emits one reassembled RISC-V instruction per cycle (16- or 32-bit) with its PC. It sits between IF2 and the fetch queue. It generalises the single-parcel partial register to an arbitrary fetch width and buffer depth. It supports misaligned block entry, instructions straddling blocks, and redirect-with-restore of a pending half instruction.

---
 rtl/bp_fe_parcel_realigner.sv | 186 ++++++++++++++++++
 tb/tb_bp_fe_parcel_realigner.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_parcel_realigner.sv
// bp_fe_parcel_realigner
//
// Fetch realigner between IF2 and the fetch queue. Whole I$ fetch blocks of
// fetch_parcels_p 16-bit parcels are pushed into a circular parcel queue.
// One RISC-V instruction (16- or 32-bit) is reassembled at the head each cycle
// and emitted with its PC. A redirect flushes the queue. It can optionally
// seed the queue with one pending low half, so that an instruction straddling
// the redirect point is rebuilt correctly.
//
// Ports
//   clk_i, reset_n_i        clock, asynchronous active-low reset
//   in_v_i / in_ready_o     fetch block handshake
//   in_pc_i                 PC of the first valid parcel in the block
//   in_data_i               block-aligned data, parcel k = bits [16k+:16]
//   redirect_v_i            flush and restart at redirect_pc_i
//   redirect_partial_v_i    restore redirect_instr_i as a pending low half
//   out_v_o / out_ready_i   instruction handshake
//   out_pc_o, out_instr_o   instruction PC and bits (compressed zero-extended)
//   out_compressed_o        head instruction is 16-bit
//   out_partial_o           32-bit instruction assembled across two blocks
//   err_discontig_o         sticky: a nonsequential block was received
module bp_fe_parcel_realigner #(
  parameter int vaddr_width_p    = 39,
  parameter int fetch_parcels_p  = 4,
  parameter int buffer_parcels_p = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         in_v_i,
  input  logic [vaddr_width_p-1:0]     in_pc_i,
  input  logic [16*fetch_parcels_p-1:0] in_data_i,
  output logic                         in_ready_o,
  input  logic                         redirect_v_i,
  input  logic [vaddr_width_p-1:0]     redirect_pc_i,
  input  logic                         redirect_partial_v_i,
  input  logic [15:0]                  redirect_instr_i,
  output logic                         out_v_o,
  input  logic                         out_ready_i,
  output logic [vaddr_width_p-1:0]     out_pc_o,
  output logic [31:0]                  out_instr_o,
  output logic                         out_compressed_o,
  output logic                         out_partial_o,
  output logic                         err_discontig_o
);

  localparam int ptr_w_lp = $clog2(buffer_parcels_p);
  localparam int cnt_w_lp = $clog2(buffer_parcels_p + 1);
  localparam int off_w_lp = $clog2(fetch_parcels_p);
  localparam logic [cnt_w_lp-1:0] depth_lp = cnt_w_lp'(buffer_parcels_p);
  localparam logic [cnt_w_lp-1:0] fetch_lp = cnt_w_lp'(fetch_parcels_p);

  // Queue state
  logic [15:0]                 data_q [buffer_parcels_p];
  logic [15:0]                 data_d [buffer_parcels_p];
  logic [buffer_parcels_p-1:0] first_q, first_d;
  logic [ptr_w_lp-1:0]         head_q, head_d;
  logic [ptr_w_lp-1:0]         tail_q, tail_d;
  logic [cnt_w_lp-1:0]         count_q, count_d;
  logic [vaddr_width_p-1:0]    head_pc_q, head_pc_d;
  logic [vaddr_width_p-1:0]    tail_pc_q, tail_pc_d;
  logic                        err_q, err_d;

  // Unpack the incoming block into parcels
  logic [15:0] in_parcel [fetch_parcels_p];
  for (genvar gi = 0; gi < fetch_parcels_p; gi++) begin : g_unpack
    assign in_parcel[gi] = in_data_i[16*gi +: 16];
  end

  // Head decode
  logic [ptr_w_lp-1:0] head_p1;
  logic [15:0]         head_lo, head_hi;
  logic                compressed;
  logic [cnt_w_lp-1:0] need;

  assign head_p1    = head_q + ptr_w_lp'(1);
  assign head_lo    = data_q[head_q];
  assign head_hi    = data_q[head_p1];
  assign compressed = (head_lo[1:0] != 2'b11);
  assign need       = compressed ? cnt_w_lp'(1) : cnt_w_lp'(2);

  assign out_v_o          = ~redirect_v_i & (count_q >= need);
  assign out_pc_o         = head_pc_q;
  assign out_instr_o      = compressed ? {16'h0000, head_lo} : {head_hi, head_lo};
  assign out_compressed_o = compressed;
  // The high half starting a new block means the halves came from two blocks.
  // Gated by out_v_o so that a stale slot never shows up while empty.
  assign out_partial_o    = out_v_o & ~compressed & first_q[head_p1];
  assign err_discontig_o  = err_q;

  // Ready is sized for a worst-case full block, from registered count only,
  // so there is no path from in_v_i or the output handshake into in_ready_o.
  assign in_ready_o = ~redirect_v_i & ((depth_lp - count_q) >= fetch_lp);

  // Enqueue decode
  logic [off_w_lp-1:0] in_off;
  logic [cnt_w_lp-1:0] in_n;
  logic                accept, discontig, enq, deq;

  assign in_off    = in_pc_i[off_w_lp:1];
  assign in_n      = fetch_lp - cnt_w_lp'(in_off);
  assign accept    = in_v_i & in_ready_o;
  // An empty queue has no expected PC, so any block restarts the stream.
  assign discontig = accept & (count_q != '0) & (in_pc_i != tail_pc_q);
  assign enq       = accept & ~discontig;
  assign deq       = out_v_o & out_ready_i;

  always_comb begin
    logic [ptr_w_lp-1:0] wr_idx;
    wr_idx    = '0;
    data_d    = data_q;
    first_d   = first_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    head_pc_d = head_pc_q;
    tail_pc_d = tail_pc_q;
    err_d     = err_q;

    if (redirect_v_i) begin
      head_d    = '0;
      head_pc_d = redirect_pc_i;
      if (redirect_partial_v_i) begin
        data_d[0]  = redirect_instr_i;
        first_d[0] = 1'b1;
        tail_d     = ptr_w_lp'(1);
        count_d    = cnt_w_lp'(1);
        tail_pc_d  = redirect_pc_i + vaddr_width_p'(2);
      end else begin
        tail_d    = '0;
        count_d   = '0;
        tail_pc_d = redirect_pc_i;
      end
    end else begin
      if (enq) begin
        // Parcels below the entry offset precede the PC and are skipped.
        for (int k = 0; k < fetch_parcels_p; k++) begin
          if (k >= int'(in_off)) begin
            wr_idx          = tail_q + ptr_w_lp'(k - int'(in_off));
            data_d[wr_idx]  = in_parcel[k];
            first_d[wr_idx] = (k == int'(in_off));
          end
        end
        tail_d    = tail_q + ptr_w_lp'(in_n);
        tail_pc_d = in_pc_i + vaddr_width_p'({in_n, 1'b0});
        if (count_q == '0) begin
          head_pc_d = in_pc_i;
        end
      end
      // A dequeue needs count_q != 0, so it never collides with the
      // head_pc load above.
      if (deq) begin
        head_d    = head_q + ptr_w_lp'(need);
        head_pc_d = head_pc_q + vaddr_width_p'({need, 1'b0});
      end
      count_d = count_q + (enq ? in_n : '0) - (deq ? need : '0);
      if (discontig) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < buffer_parcels_p; i++) begin
        data_q[i] <= '0;
      end
      first_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      head_pc_q <= '0;
      tail_pc_q <= '0;
      err_q     <= 1'b0;
    end else begin
      data_q    <= data_d;
      first_q   <= first_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      head_pc_q <= head_pc_d;
      tail_pc_q <= tail_pc_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_bp_fe_parcel_realigner.sv
// Directed testbench for bp_fe_parcel_realigner (default parameters:
// 39-bit addresses, 4-parcel blocks, 8-parcel queue).
module tb_bp_fe_parcel_realigner;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        in_v_i;
  logic [38:0] in_pc_i;
  logic [63:0] in_data_i;
  logic        in_ready_o;
  logic        redirect_v_i;
  logic [38:0] redirect_pc_i;
  logic        redirect_partial_v_i;
  logic [15:0] redirect_instr_i;
  logic        out_v_o;
  logic        out_ready_i;
  logic [38:0] out_pc_o;
  logic [31:0] out_instr_o;
  logic        out_compressed_o;
  logic        out_partial_o;
  logic        err_discontig_o;

  int errors = 0;
  int checks = 0;

  bp_fe_parcel_realigner dut (
    .clk_i                (clk_i),
    .reset_n_i            (reset_n_i),
    .in_v_i               (in_v_i),
    .in_pc_i              (in_pc_i),
    .in_data_i            (in_data_i),
    .in_ready_o           (in_ready_o),
    .redirect_v_i         (redirect_v_i),
    .redirect_pc_i        (redirect_pc_i),
    .redirect_partial_v_i (redirect_partial_v_i),
    .redirect_instr_i     (redirect_instr_i),
    .out_v_o              (out_v_o),
    .out_ready_i          (out_ready_i),
    .out_pc_o             (out_pc_o),
    .out_instr_o          (out_instr_o),
    .out_compressed_o     (out_compressed_o),
    .out_partial_o        (out_partial_o),
    .err_discontig_o      (err_discontig_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic blk(input logic [38:0] pc, input logic [63:0] data);
    in_v_i    = 1'b1;
    in_pc_i   = pc;
    in_data_i = data;
  endtask

  task automatic chk_out(input string tag, input logic [38:0] pc, input logic [31:0] instr,
                         input logic cmp, input logic part);
    chk({tag, ".v"}, 64'(out_v_o), 64'd1);
    chk({tag, ".pc"}, 64'(out_pc_o), 64'(pc));
    chk({tag, ".instr"}, 64'(out_instr_o), 64'(instr));
    chk({tag, ".c"}, 64'(out_compressed_o), 64'(cmp));
    chk({tag, ".partial"}, 64'(out_partial_o), 64'(part));
    $display("out pc=%0h instr=%08h c=%0b partial=%0b", out_pc_o, out_instr_o,
             out_compressed_o, out_partial_o);
  endtask

  initial begin
    reset_n_i = 1'b0;
    in_v_i = 1'b0; in_pc_i = '0; in_data_i = '0;
    redirect_v_i = 1'b0; redirect_pc_i = '0;
    redirect_partial_v_i = 1'b0; redirect_instr_i = '0;
    out_ready_i = 1'b0;

    // Reset state
    cyc(); cyc();
    chk("rst.out_v", 64'(out_v_o), 64'd0);
    chk("rst.in_ready", 64'(in_ready_o), 64'd1);
    chk("rst.err", 64'(err_discontig_o), 64'd0);
    chk("rst.partial", 64'(out_partial_o), 64'd0);
    reset_n_i = 1'b1;
    cyc();

    // Aligned stream
    out_ready_i = 1'b1;
    blk(39'h1000, 64'h0001_0001_0001_0001); #1;
    chk("al.in_ready", 64'(in_ready_o), 64'd1);
    chk("al.empty", 64'(out_v_o), 64'd0);
    cyc();
    blk(39'h1008, 64'h0001_0001_0001_0001); #1;
    chk_out("al0", 39'h1000, 32'h1, 1'b1, 1'b0);
    cyc();
    in_v_i = 1'b0;
    for (int i = 1; i < 8; i++) begin
      #1; chk_out("al", 39'h1000 + 39'(2 * i), 32'h1, 1'b1, 1'b0);
      cyc();
    end
    #1; chk("al.drained", 64'(out_v_o), 64'd0);
    cyc();

    // Straddle across blocks
    blk(39'h2000, {16'h0073, 16'h0001, 16'h0001, 16'h0013}); #1;
    cyc();
    in_v_i = 1'b0; #1;
    chk_out("st32", 39'h2000, 32'h0001_0013, 1'b0, 1'b0);
    cyc();
    #1; chk_out("st16", 39'h2004, 32'h1, 1'b1, 1'b0);
    cyc();
    blk(39'h2008, {16'h0001, 16'h0001, 16'h0001, 16'h0000}); #1;
    chk("st.lone_half", 64'(out_v_o), 64'd0);
    chk("st.in_ready", 64'(in_ready_o), 64'd1);
    cyc();
    in_v_i = 1'b0; #1;
    chk_out("st.straddle", 39'h2006, 32'h0000_0073, 1'b0, 1'b1);
    cyc();
    for (int i = 0; i < 3; i++) begin
      #1; chk_out("st.tail", 39'h200A + 39'(2 * i), 32'h1, 1'b1, 1'b0);
      cyc();
    end
    #1; chk("st.drained", 64'(out_v_o), 64'd0);
    cyc();

    // Misaligned entry: only parcels 2 and 3 enter the queue
    blk(39'h3004, {16'h0009, 16'h0005, 16'hFFFF, 16'hFFFF}); #1;
    cyc();
    blk(39'h3008, 64'h000D_000D_000D_000D); #1;
    chk_out("mis0", 39'h3004, 32'h5, 1'b1, 1'b0);
    cyc();
    in_v_i = 1'b0; #1;
    chk_out("mis1", 39'h3006, 32'h9, 1'b1, 1'b0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      #1; chk_out("mis.next", 39'h3008 + 39'(2 * i), 32'hD, 1'b1, 1'b0);
      cyc();
    end
    #1;
    chk("mis.drained", 64'(out_v_o), 64'd0);
    chk("mis.err", 64'(err_discontig_o), 64'd0);
    cyc();

    // Backpressure: parcels 0x0101 + 4*i at PC 0x6000 + 2*i
    out_ready_i = 1'b0;
    blk(39'h6000, {16'h010D, 16'h0109, 16'h0105, 16'h0101}); #1;
    chk("bp.rdy0", 64'(in_ready_o), 64'd1);
    cyc();
    blk(39'h6008, {16'h011D, 16'h0119, 16'h0115, 16'h0111}); #1;
    chk("bp.rdy1", 64'(in_ready_o), 64'd1);
    chk("bp.v_stalled", 64'(out_v_o), 64'd1);
    cyc();
    blk(39'h6010, {16'h012D, 16'h0129, 16'h0125, 16'h0121}); #1;
    chk("bp.full", 64'(in_ready_o), 64'd0);
    cyc();
    out_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp.rdy", 64'(in_ready_o), (i == 4) ? 64'd1 : 64'd0);
      chk_out("bp", 39'h6000 + 39'(2 * i), 32'h0101 + 32'(4 * i), 1'b1, 1'b0);
      cyc();
    end
    in_v_i = 1'b0;
    for (int i = 5; i < 12; i++) begin
      #1; chk_out("bp", 39'h6000 + 39'(2 * i), 32'h0101 + 32'(4 * i), 1'b1, 1'b0);
      cyc();
    end
    #1;
    chk("bp.drained", 64'(out_v_o), 64'd0);
    chk("bp.err", 64'(err_discontig_o), 64'd0);
    cyc();

    // Redirect with restore of a pending low half
    out_ready_i = 1'b0;
    blk(39'h7000, 64'h0001_0001_0001_0001); #1;
    cyc();
    blk(39'h7008, 64'h0001_0001_0001_0001);
    out_ready_i = 1'b1;
    redirect_v_i = 1'b1; redirect_pc_i = 39'h4FFE;
    redirect_partial_v_i = 1'b1; redirect_instr_i = 16'h0517; #1;
    chk("rd.out_v", 64'(out_v_o), 64'd0);
    chk("rd.in_ready", 64'(in_ready_o), 64'd0);
    cyc();
    redirect_v_i = 1'b0; redirect_partial_v_i = 1'b0;
    blk(39'h5000, {16'h0001, 16'h0001, 16'h0001, 16'h0000}); #1;
    chk("rd.lone_half", 64'(out_v_o), 64'd0);
    cyc();
    in_v_i = 1'b0; #1;
    chk_out("rd.restore", 39'h4FFE, 32'h0000_0517, 1'b0, 1'b1);
    cyc();
    for (int i = 0; i < 3; i++) begin
      #1; chk_out("rd.tail", 39'h5002 + 39'(2 * i), 32'h1, 1'b1, 1'b0);
      cyc();
    end
    #1;
    chk("rd.drained", 64'(out_v_o), 64'd0);
    chk("rd.err", 64'(err_discontig_o), 64'd0);
    cyc();

    // Discontinuity: wrong-PC block dropped, error sticky
    out_ready_i = 1'b0;
    blk(39'h8000, 64'h0001_0001_0001_0001); #1;
    cyc();
    blk(39'h9000, 64'h0005_0005_0005_0005); #1;
    chk("dc.in_ready", 64'(in_ready_o), 64'd1);
    cyc();
    in_v_i = 1'b0; out_ready_i = 1'b1; #1;
    chk("dc.err", 64'(err_discontig_o), 64'd1);
    for (int i = 0; i < 4; i++) begin
      if (i != 0) #1;
      chk_out("dc", 39'h8000 + 39'(2 * i), 32'h1, 1'b1, 1'b0);
      cyc();
    end
    #1;
    chk("dc.dropped", 64'(out_v_o), 64'd0);
    chk("dc.sticky", 64'(err_discontig_o), 64'd1);
    cyc();

    // Asynchronous reset mid-stream
    out_ready_i = 1'b0;
    blk(39'hA000, 64'h0001_0001_0001_0001); #1;
    cyc();
    in_v_i = 1'b0; #1;
    chk("ar.pre_v", 64'(out_v_o), 64'd1);
    reset_n_i = 1'b0; #1;
    chk("ar.out_v", 64'(out_v_o), 64'd0);
    chk("ar.err", 64'(err_discontig_o), 64'd0);
    chk("ar.in_ready", 64'(in_ready_o), 64'd1);
    cyc(); cyc();
    reset_n_i = 1'b1;
    cyc();
    #1;
    chk("ar.after_v", 64'(out_v_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
